tx_byte_sequencer: RTL
======================

Name: tx_byte_sequencer

Overview:
- Controller that sequences the TX bit-timing and shift datapath for one outgoing frame.
- Fetches bytes from the upstream TX FIFO over a valid/ready handshake and loads them into an internal shift register.
- Generates per-bit shift enables from an internal bit-period counter, honours pause/abort, and signals byte and frame completion to the packet-level TX FSM.

Parameters:
- CLKS_PER_BIT, 8, clk cycles per serial bit; legal range 2..255.
- LEN_W, 11, width of frame_len and the byte counter; max frame 2^LEN_W-1 bytes.
- GAP_CLKS, 4, idle-high cycles inserted between bytes; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin a frame; sampled only in IDLE.
- frame_len  in  LEN_W  byte count, latched on accepted start.
- byte_valid  in  1  FIFO has a byte.
- byte_data  in  8  FIFO byte, transmitted LSB first.
- byte_ready  out  1  sequencer accepts byte this cycle.
- pause  in  1  freeze timing and handshake while high.
- abort  in  1  terminate frame immediately.
- tx_bit  out  1  serial data; 1 when not shifting.
- shift_en  out  1  one-cycle pulse at each bit boundary.
- byte_done  out  1  pulse with the 8th shift_en of a byte.
- frame_done  out  1  pulse when the frame completes normally.
- busy  out  1  high in any state other than IDLE.
- underrun  out  1  sticky flag: FIFO empty mid-frame; cleared on accepted start.

Behaviour:
- One clock and a synchronous active-low reset: all registers are updated on the clk rising edge, and n_rst=0 is sampled on that edge.
- Reset values: state=IDLE, counters=0, shreg=0, underrun=0; outputs tx_bit=1, all other outputs 0.
- States: IDLE, FETCH, SHIFT, GAP (optional), DONE.
- IDLE:
  - start=1 and frame_len>0 -> FETCH; latch frame_len, byte_cnt=0, clear underrun.
  - start=1 and frame_len=0 -> DONE; no byte is fetched.
- FETCH:
  - byte_ready = (state==FETCH) & ~pause, combinational.
  - A transfer occurs when byte_valid & byte_ready. It loads shreg<=byte_data, bit_idx=0, bit_cnt=0, and moves to SHIFT.
  - If byte_valid=0, pause=0 and byte_cnt>0, set underrun and remain in FETCH; tx_bit stays 1.
- SHIFT:
  - tx_bit=shreg[0].
  - bit_cnt increments each non-paused cycle.
  - When bit_cnt==CLKS_PER_BIT-1 and pause=0, shift_en=1 (combinational) and on that edge: shreg>>=1, bit_cnt<=0, bit_idx++.
  - When shift_en fires with bit_idx==7, byte_done=1 in the same cycle and byte_cnt++.
  - If byte_cnt+1==frame_len -> DONE; otherwise -> FETCH (or GAP with the optional feature).
- DONE: frame_done=1 for exactly one cycle, then IDLE.
- Latency:
  - start at cycle 0 -> byte_ready at cycle 1.
  - With valid high, SHIFT at cycle 2 and first shift_en at cycle 1+CLKS_PER_BIT.
  - Each byte occupies 8*CLKS_PER_BIT SHIFT cycles plus at least 1 FETCH cycle.
- pause:
  - Holds state, bit_cnt, shreg and tx_bit.
  - Forces shift_en, byte_ready and byte_done to 0.
  - Does not suppress the underrun check while low.
- abort:
  - Highest priority. From any state it returns to IDLE on the next edge.
  - No frame_done or byte_done in that cycle; tx_bit=1 from the next cycle.
  - The partial byte is discarded and underrun is preserved.
- Simultaneous events:
  - abort wins over start, pause and shift_en completion.
  - A start received while busy is ignored.
  - pause together with a bit-boundary cycle defers that boundary until pause drops.
- Width rules:
  - byte_cnt is LEN_W bits and compared to the latched length; it never wraps, because a frame ends at frame_len.
  - bit_cnt is clog2(CLKS_PER_BIT) bits.

Optional Feature:
- Macro TX_SEQ_INTERBYTE_GAP_EN.
- Defined:
  - After byte_done on a non-final byte, enter GAP for GAP_CLKS non-paused cycles with tx_bit=1, then FETCH.
  - pause freezes the gap counter; abort exits to IDLE.
- Undefined: the GAP state and its counter are absent, and SHIFT goes directly to FETCH.

Test Plan:
- Reset: hold n_rst=0 for 3 clks mid-SHIFT -> next cycle IDLE, tx_bit=1, busy=0, all pulses 0.
- Single byte: frame_len=1, byte_data=0xA5, valid always high, CLKS_PER_BIT=8:
  - tx_bit sequence 1,0,1,0,0,1,0,1, each 8 clks.
  - 8 shift_en pulses; byte_done and the following-cycle transition to DONE.
  - frame_done exactly 1 cycle, 67 cycles after start.
- Multi-byte with underrun: frame_len=3, valid drops for 10 clks before byte 2 -> underrun=1 sticky, tx_bit=1 during the wait, frame still completes with 3 byte_done pulses.
- Pause: assert pause for 5 clks at bit_cnt=3 of bit 4 -> that bit lasts 13 clks, no shift_en during pause, data unchanged.
- Abort and zero-length:
  - Abort during bit 2 of byte 1 of a 4-byte frame -> IDLE next cycle, no frame_done, a new start is accepted immediately.
  - start with frame_len=0 -> frame_done one cycle after DONE entry, byte_ready never asserted.
- Gap (macro defined, GAP_CLKS=4): frame_len=2 -> exactly 4 idle-high cycles between byte_done and byte_ready; with macro undefined, byte_ready follows byte_done on the next cycle.

Source files
------------

// File: rtl/tx_byte_sequencer.sv
// rtl/tx_byte_sequencer.sv - TX byte fetch, bit timing and shift sequencer for one frame
// Optional inter-byte idle gap enabled by defining TX_SEQ_INTERBYTE_GAP_EN.
module tx_byte_sequencer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int LEN_W        = 11,
    parameter int GAP_CLKS     = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    input  logic             pause,
    input  logic             abort,
    output logic             tx_bit,
    output logic             shift_en,
    output logic             byte_done,
    output logic             frame_done,
    output logic             busy,
    output logic             underrun
);

    localparam int BW = ($clog2(CLKS_PER_BIT) > 0) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        DONE
`ifdef TX_SEQ_INTERBYTE_GAP_EN
        , GAP
`endif
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] byte_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             last_byte;

`ifdef TX_SEQ_INTERBYTE_GAP_EN
    localparam int GW = ($clog2(GAP_CLKS) > 0) ? $clog2(GAP_CLKS) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLKS - 1);
    logic [GW-1:0] gap_cnt;
`endif

    // abort outranks every completion event, so the pulses are gated by it as well
    assign shift_en   = (state == SHIFT) && (bit_cnt == BIT_LAST) && !pause && !abort;
    assign byte_done  = shift_en && (bit_idx == 3'd7);
    assign byte_ready = (state == FETCH) && !pause && !abort;
    assign tx_bit     = (state == SHIFT) ? shreg[0] : 1'b1;
    assign busy       = (state != IDLE);
    assign last_byte  = ((byte_cnt + LEN_W'(1)) == len_q);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= IDLE;
            len_q      <= '0;
            byte_cnt   <= '0;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            underrun   <= 1'b0;
            frame_done <= 1'b0;
`ifdef TX_SEQ_INTERBYTE_GAP_EN
            gap_cnt    <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            len_q    <= frame_len;
                            byte_cnt <= '0;
                            underrun <= 1'b0;
                            state    <= (frame_len != '0) ? FETCH : DONE;
                        end
                    end
                    FETCH: begin
                        if (byte_valid && byte_ready) begin
                            shreg   <= byte_data;
                            bit_idx <= '0;
                            bit_cnt <= '0;
                            state   <= SHIFT;
                        end else if (!byte_valid && !pause && (byte_cnt != '0)) begin
                            underrun <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (!pause) begin
                            if (bit_cnt == BIT_LAST) begin
                                shreg   <= shreg >> 1;
                                bit_cnt <= '0;
                                bit_idx <= bit_idx + 3'd1;
                                if (bit_idx == 3'd7) begin
                                    byte_cnt <= byte_cnt + LEN_W'(1);
                                    if (last_byte) begin
                                        state <= DONE;
                                    end else begin
`ifdef TX_SEQ_INTERBYTE_GAP_EN
                                        gap_cnt <= '0;
                                        state   <= GAP;
`else
                                        state   <= FETCH;
`endif
                                    end
                                end
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end
                    end
`ifdef TX_SEQ_INTERBYTE_GAP_EN
                    GAP: begin
                        if (!pause) begin
                            if (gap_cnt == GAP_LAST) begin
                                state <= FETCH;
                            end else begin
                                gap_cnt <= gap_cnt + GW'(1);
                            end
                        end
                    end
`endif
                    DONE: begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
